bottom_linear_pipe: RTL and testbench
=====================================

Name: bottom_linear_pipe

Overview:
- Parametrised, pipelined, multi-lane successor to the combinational forward bottom linear transform of the depth-16 AES S-box.
- Each lane maps 63 nonlinear products M[62:0] to one S-box output byte S[7:0].
- Lanes are processed in lockstep behind a valid/ready elastic pipeline.
- Sits between the nonlinear middle section and the SubBytes/round datapath; with NUM_LANES=4 it serves a 32-bit column, with NUM_LANES=16 the full state.

Parameters:
- NUM_LANES, 4, number of independent 63-bit-to-8-bit lanes (1..16).
- PIPE_STAGES, 2, register stages. 0 = combinational pass-through; 1 = S register only; 2 = L register then S register.
- OUT_CONST, 8'h63, constant XORed onto every lane's linear result. 8'h63 reproduces the standard forward S-box.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept input this cycle.
- in_m  in  63*NUM_LANES  lane k occupies bits [63k+62:63k], with M index 0..62.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts output.
- out_s  out  8*NUM_LANES  lane k occupies bits [8k+7:8k].
- err  out  1  sticky duplicate-compare mismatch. Present only when BLF_DUP_CHECK_EN is defined.

Behaviour:
- Per-lane L network, with + meaning XOR:
  - L0=M60+M61, L1=M49+M55, L2=M45+M47, L3=M46+M54, L4=M53+M57
  - L5=M48+M60, L6=M61+L5, L7=M45+L3, L8=M50+M58, L9=M51+M52
  - L10=M52+L4, L11=M59+L2, L12=M47+M50, L13=M49+L0, L14=M51+M60
  - L15=M54+L1, L16=M55+L0, L17=M56+L1, L18=M57+L8, L19=M62+L4
  - L20=L0+L1, L21=L1+L7, L22=L3+L12, L23=L18+L2, L24=L15+L9
  - L25=L6+L10, L26=L7+L9, L27=L8+L10, L28=L11+L14, L29=L11+L17
- Linear outputs:
  - T7=L6+L24, T6=L16+L26, T5=L19+L28, T4=L6+L21
  - T3=L20+L22, T2=L25+L29, T1=L13+L27, T0=L6+L23
- Final output: S = T ^ OUT_CONST.
- Stage handshake: each stage holds a valid bit. A stage loads when it is empty or its successor accepts (stage_ready = ~v | next_ready).
  - in_ready = first stage's ready.
  - out_valid = last stage's valid.
  - A transfer occurs on in_valid&in_ready (input side) or out_valid&out_ready (output side).
- Latency: exactly PIPE_STAGES cycles from input transfer to out_valid with out_ready held high.
- Throughput: 1 word/cycle with no bubbles.
- Backpressure: out_ready low holds out_s and out_valid stable. Upstream stages fill, then in_ready drops. No data is lost or duplicated.
- Simultaneous load and drain of a full stage is allowed (pass-through replacement in the same cycle).
- PIPE_STAGES=0: in_ready=out_ready, out_valid=in_valid, out_s combinational. rst has no effect on the datapath.
- Reset (rst high at a clk edge):
  - All valid bits clear, L and S data registers clear to 0.
  - out_valid=0 and out_s=0 after the edge; in_ready=1 the cycle after.
  - In-flight words are discarded. Reset mid-stall is permitted.
- Data registers load only on stage transfer (no toggling while stalled).
- Lanes never interact; lane k output depends only on lane k input.

Optional Feature:
- Macro: BLF_DUP_CHECK_EN.
- When defined:
  - A second, independently instantiated copy of the L/T network computes every lane.
  - Its S result travels in a parallel shadow register chain and is compared with out_s whenever out_valid=1.
  - Any mismatch sets err at the next edge; err stays 1 until rst.
  - Port err exists; synthesis keep attributes are placed on the duplicate copy.
- When undefined: no duplicate logic, no err port, area as single copy.

Test Plan:
- NUM_LANES=4, PIPE_STAGES=2, out_ready=1. in_m lane0=0, lane1=all ones, lane2=only M60=1, lane3=0 -> exactly 2 cycles later out_valid=1, out_s=32'h639C6363 (lane3..lane0).
- Streaming: 20 back-to-back random words with out_ready=1 -> 20 outputs in order, 1/cycle, each matching the golden L/T model, in_ready never low.
- Backpressure: out_ready=0 for 5 cycles during a stream -> out_s stable; in_ready falls after 2 accepted words are buffered. On out_ready=1, no loss or duplication; order preserved.
- Reset mid-operation: assert rst with 2 words in flight -> next cycle out_valid=0, out_s=0; in_ready=1 the following cycle; no stale word appears later.
- PIPE_STAGES=0 and PIPE_STAGES=1 builds, OUT_CONST=8'h00 -> zero input gives out_s=0; latency 0 and 1 respectively; in_ready tracks out_ready (stage 0).
- BLF_DUP_CHECK_EN defined: force one bit of the primary S register -> err=1 next cycle and sticky until rst. Without the force, err stays 0 over 1000 random words.

Source files
------------

// File: rtl/bottom_linear_pipe.sv
// Pipelined multi-lane bottom linear layer of the depth-16 AES S-box: 63 products -> 1 byte per lane.
// Define BLF_DUP_CHECK_EN to add a duplicated network, a shadow register chain and a sticky err output.
module bottom_linear_pipe #(
  parameter int          NUM_LANES   = 4,
  parameter int          PIPE_STAGES = 2,
  parameter logic [7:0]  OUT_CONST   = 8'h63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63*NUM_LANES-1:0]  in_m,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*NUM_LANES-1:0]   out_s
`ifdef BLF_DUP_CHECK_EN
  ,
  output logic                     err
`endif
);

  localparam int TW = 14;              // L terms that feed the T layer
  localparam int LW = TW * NUM_LANES;
  localparam int SW = 8 * NUM_LANES;

  // Returns only the L terms consumed by the T layer: {L29..L20, L19, L16, L13, L6}.
  function automatic logic [TW-1:0] l_net(input logic [62:0] m);
    logic [29:0] l;
    l[0]  = m[60] ^ m[61];  l[1]  = m[49] ^ m[55];  l[2]  = m[45] ^ m[47];
    l[3]  = m[46] ^ m[54];  l[4]  = m[53] ^ m[57];  l[5]  = m[48] ^ m[60];
    l[6]  = m[61] ^ l[5];   l[7]  = m[45] ^ l[3];   l[8]  = m[50] ^ m[58];
    l[9]  = m[51] ^ m[52];  l[10] = m[52] ^ l[4];   l[11] = m[59] ^ l[2];
    l[12] = m[47] ^ m[50];  l[13] = m[49] ^ l[0];   l[14] = m[51] ^ m[60];
    l[15] = m[54] ^ l[1];   l[16] = m[55] ^ l[0];   l[17] = m[56] ^ l[1];
    l[18] = m[57] ^ l[8];   l[19] = m[62] ^ l[4];
    l[20] = l[0]  ^ l[1];   l[21] = l[1]  ^ l[7];   l[22] = l[3]  ^ l[12];
    l[23] = l[18] ^ l[2];   l[24] = l[15] ^ l[9];   l[25] = l[6]  ^ l[10];
    l[26] = l[7]  ^ l[9];   l[27] = l[8]  ^ l[10];  l[28] = l[11] ^ l[14];
    l[29] = l[11] ^ l[17];
    return {l[29:20], l[19], l[16], l[13], l[6]};
  endfunction

  function automatic logic [7:0] t_net(input logic [TW-1:0] p);
    return {p[0] ^ p[8],  p[2] ^ p[10], p[3] ^ p[12], p[0] ^ p[5],
            p[4] ^ p[6],  p[9] ^ p[13], p[1] ^ p[11], p[0] ^ p[7]};
  endfunction

  logic            l_valid_q, l_valid_d, s_valid_q, s_valid_d;
  logic [LW-1:0]   l_q, l_d;
  logic [SW-1:0]   s_q, s_d;
  logic            l_ready, s_ready, l_load, s_load;
  logic [LW-1:0]   l_in;
  logic [SW-1:0]   s_in, s_l;
  logic            unused_m;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    l_in     = '0;
    s_in     = '0;
    s_l      = '0;
    unused_m = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      l_in[k*TW +: TW] = l_net(in_m[k*63 +: 63]);
      s_in[k*8 +: 8]   = t_net(l_in[k*TW +: TW]) ^ OUT_CONST;
      s_l[k*8 +: 8]    = t_net(l_q[k*TW +: TW]) ^ OUT_CONST;
      unused_m         = unused_m ^ (^in_m[k*63 +: 45]);  // M0..M44 do not reach the output
    end
  end

  always_comb begin
    s_ready   = ~s_valid_q | out_ready;
    l_ready   = ~l_valid_q | s_ready;
    l_valid_d = l_valid_q;
    s_valid_d = s_valid_q;
    l_load    = 1'b0;
    s_load    = 1'b0;
    in_ready  = out_ready;
    out_valid = in_valid;
    out_s     = s_in;
    case (PIPE_STAGES)
      2: begin
        in_ready = l_ready;
        if (l_ready) l_valid_d = in_valid;
        if (s_ready) s_valid_d = l_valid_q;
        l_load    = in_valid & l_ready;
        s_load    = l_valid_q & s_ready;
        out_valid = s_valid_q;
        out_s     = s_q;
      end
      1: begin
        in_ready = s_ready;
        if (s_ready) s_valid_d = in_valid;
        s_load    = in_valid & s_ready;
        out_valid = s_valid_q;
        out_s     = s_q;
      end
      default: ;
    endcase
    l_d = l_load ? l_in : l_q;
    s_d = s_load ? ((PIPE_STAGES == 2) ? s_l : s_in) : s_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: data registers are cleared too, so out_s reads 0 straight after reset.
      l_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      l_q       <= '0;
      s_q       <= '0;
    end else begin
      l_valid_q <= l_valid_d;
      s_valid_q <= s_valid_d;
      l_q       <= l_d;
      s_q       <= s_d;
    end
  end

`ifdef BLF_DUP_CHECK_EN
  (* keep *) logic [LW-1:0] dup_l_in;
  (* keep *) logic [SW-1:0] dup_s_in;
  (* keep *) logic [SW-1:0] dup_s_l;
  (* keep *) logic [LW-1:0] dup_l_q;
  (* keep *) logic [SW-1:0] dup_s_q;
  logic [LW-1:0] dup_l_d;
  logic [SW-1:0] dup_s_d, dup_out_s;
  logic          err_q, err_d;

  always_comb begin
    dup_l_in = '0;
    dup_s_in = '0;
    dup_s_l  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      dup_l_in[k*TW +: TW] = l_net(in_m[k*63 +: 63]);
      dup_s_in[k*8 +: 8]   = t_net(dup_l_in[k*TW +: TW]) ^ OUT_CONST;
      dup_s_l[k*8 +: 8]    = t_net(dup_l_q[k*TW +: TW]) ^ OUT_CONST;
    end
    // Shadow chain shares the primary load enables so both copies hold the same word.
    dup_l_d   = l_load ? dup_l_in : dup_l_q;
    dup_s_d   = s_load ? ((PIPE_STAGES == 2) ? dup_s_l : dup_s_in) : dup_s_q;
    dup_out_s = (PIPE_STAGES == 0) ? dup_s_in : dup_s_q;
    err_d     = err_q | (out_valid & (out_s != dup_out_s));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dup_l_q <= '0;
      dup_s_q <= '0;
      err_q   <= 1'b0;
    end else begin
      dup_l_q <= dup_l_d;
      dup_s_q <= dup_s_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_bottom_linear_pipe.sv
// Bench for bottom_linear_pipe: three builds (2, 0 and 1 stages) checked against a netlist-table model
// with per-instance expectation queues, plus directed literal vectors, backpressure and reset cases.
module tb_bottom_linear_pipe;
  localparam int NL  = 4;
  localparam int W   = 63 * NL;
  localparam int SWD = 8 * NL;
  localparam int ND  = 3;
`ifdef BLF_DUP_CHECK_EN
  localparam int N_RAND = 1000;
`else
  localparam int N_RAND = 200;
`endif

  localparam logic [7:0] DCONST [ND]  = '{8'h63, 8'h00, 8'h00};
  localparam int         DSTAGES [ND] = '{2, 0, 1};

  // L/T network as a table: operand < 100 is M index, >= 100 is L(operand-100).
  localparam int LA [30] = '{60, 49, 45, 46, 53, 48, 61, 45, 50, 51,
                             52, 59, 47, 49, 51, 54, 55, 56, 57, 62,
                             100, 101, 103, 118, 115, 106, 107, 108, 111, 111};
  localparam int LB [30] = '{61, 55, 47, 54, 57, 60, 105, 103, 58, 52,
                             104, 102, 50, 100, 60, 101, 100, 101, 108, 104,
                             101, 107, 112, 102, 109, 110, 109, 110, 114, 117};
  localparam int TA [8]  = '{6, 13, 25, 20, 6, 19, 16, 6};
  localparam int TB [8]  = '{23, 27, 29, 22, 21, 28, 26, 24};

  logic           clk = 1'b0;
  logic           rst, in_valid, out_ready;
  logic [W-1:0]   in_m;
  logic [ND-1:0]  ir, ov;
  logic [SWD-1:0] os [ND];
`ifdef BLF_DUP_CHECK_EN
  logic [ND-1:0]  er;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bottom_linear_pipe #(.NUM_LANES(NL), .PIPE_STAGES(2), .OUT_CONST(8'h63)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_m(in_m),
    .out_valid(ov[0]), .out_ready(out_ready), .out_s(os[0])
`ifdef BLF_DUP_CHECK_EN
    , .err(er[0])
`endif
  );

  bottom_linear_pipe #(.NUM_LANES(NL), .PIPE_STAGES(0), .OUT_CONST(8'h00)) u_dut_p0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_m(in_m),
    .out_valid(ov[1]), .out_ready(out_ready), .out_s(os[1])
`ifdef BLF_DUP_CHECK_EN
    , .err(er[1])
`endif
  );

  bottom_linear_pipe #(.NUM_LANES(NL), .PIPE_STAGES(1), .OUT_CONST(8'h00)) u_dut_p1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_m(in_m),
    .out_valid(ov[2]), .out_ready(out_ready), .out_s(os[2])
`ifdef BLF_DUP_CHECK_EN
    , .err(er[2])
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [SWD-1:0] model_s(input logic [W-1:0] w, input logic [7:0] c);
    logic [SWD-1:0] r;
    bit m [63];
    bit l [30];
    bit a, b;
    r = '0;
    for (int k = 0; k < NL; k++) begin
      for (int j = 0; j < 63; j++) m[j] = w[k*63 + j];
      for (int j = 0; j < 30; j++) begin
        if (LA[j] >= 100) a = l[LA[j] - 100]; else a = m[LA[j]];
        if (LB[j] >= 100) b = l[LB[j] - 100]; else b = m[LB[j]];
        l[j] = a ^ b;
      end
      for (int t = 0; t < 8; t++) r[k*8 + t] = l[TA[t]] ^ l[TB[t]] ^ c[t];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < W; i += 32) v[i +: 32] = $urandom;
    return v;
  endfunction

  // Scoreboard: one expectation queue per instance, filled on input transfers, drained on output transfers.
  logic [SWD-1:0] exp_q [ND][$];
  int             out_cnt [ND];
  bit             chk_en = 1'b1;
  bit             pv [ND];
  bit             pr = 1'b1;
  logic [SWD-1:0] ps [ND];

  initial for (int i = 0; i < ND; i++) begin out_cnt[i] = 0; pv[i] = 1'b0; ps[i] = '0; end

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < ND; i++) begin exp_q[i].delete(); pv[i] = 1'b0; end
      pr = 1'b1;
    end else begin
      for (int i = 0; i < ND; i++) begin
        if (in_valid && ir[i]) exp_q[i].push_back(model_s(in_m, DCONST[i]));
        if (chk_en && DSTAGES[i] > 0 && pv[i] && !pr) begin
          check($sformatf("stall_valid[%0d]", i), ov[i], 1);
          check($sformatf("stall_data[%0d]", i), os[i], ps[i]);
        end
        if (ov[i] && out_ready) begin
          if (exp_q[i].size() == 0) begin
            if (chk_en) check($sformatf("unexpected_out[%0d]", i), ov[i], 0);
          end else begin
            logic [SWD-1:0] e;
            e = exp_q[i].pop_front();
            if (chk_en) check($sformatf("out_data[%0d]", i), os[i], e);
            out_cnt[i]++;
          end
        end
        pv[i] = ov[i];
        ps[i] = os[i];
      end
      pr = out_ready;
`ifdef BLF_DUP_CHECK_EN
      if (chk_en) for (int i = 0; i < ND; i++) check($sformatf("err_quiet[%0d]", i), er[i], 0);
`endif
    end
  end

  task automatic send(input logic [W-1:0] w, output int waits);
    bit acc;
    in_valid = 1'b1;
    in_m     = w;
    waits    = 0;
    acc      = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = ir[0];
      @(posedge clk); #1;
      if (acc) break;
      waits++;
    end
    if (!acc) check("send_timeout", acc, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Latency walk: the 0-stage build shows the word at once, the 1-stage one cycle later, the 2-stage two.
  task automatic directed(input logic [W-1:0] v, input logic [31:0] e63, input logic [31:0] e00);
    in_valid = 1'b1;
    in_m     = v;
    @(negedge clk);
    check("lat0_main_valid", ov[0], 0);
    check("lat0_p0_valid", ov[1], 1);
    check("lat0_p0_data", os[1], e00);
    check("lat0_p1_valid", ov[2], 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat1_main_valid", ov[0], 0);
    check("lat1_p1_valid", ov[2], 1);
    check("lat1_p1_data", os[2], e00);
    check("lat1_p0_valid", ov[1], 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat2_main_valid", ov[0], 1);
    check("lat2_main_data", os[0], e63);
    check("lat2_p1_valid", ov[2], 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] va, vc;
    logic [W-1:0] bw [6];
    int w, stalls, c0, acc_n;
    bit a;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_m = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", ov[0], 0);
    check("reset_out_s", os[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", ir[0], 1);
    @(posedge clk); #1;

    va = '0; va[125:63] = '1; va[126 + 60] = 1'b1;
    vc = '0; vc[189 + 60] = 1'b1;
    directed(va, 32'h639C6363, 32'h00FF0000);
    directed('0, 32'h63636363, 32'h00000000);
    directed(vc, 32'h9C636363, 32'hFF000000);

    out_ready = 1'b0;
    @(negedge clk);
    check("p0_ready_tracks_low", ir[1], 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("p0_ready_tracks_high", ir[1], 1);
    @(posedge clk); #1;

    // Streaming: back-to-back words must never stall with out_ready high.
    c0 = out_cnt[0]; stalls = 0;
    for (int i = 0; i < 20; i++) begin send(rand_word(), w); stalls += w; end
    idle(3);
    check("stream_stalls", stalls, 0);
    check("stream_outputs", out_cnt[0] - c0, 20);

    // Backpressure from an empty pipe: exactly two words fit before in_ready drops.
    for (int i = 0; i < 6; i++) bw[i] = rand_word();
    c0 = out_cnt[0]; acc_n = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_m = bw[acc_n];
      @(negedge clk);
      a = ir[0];
      @(posedge clk); #1;
      if (a) acc_n++;
    end
    check("bp_accepted", acc_n, 2);
    @(negedge clk);
    check("bp_in_ready_low", ir[0], 0);
    check("bp_out_valid", ov[0], 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = acc_n; i < 6; i++) send(bw[i], w);
    idle(4);
    check("bp_outputs", out_cnt[0] - c0, 6);

    // Reset with two words in flight: both must vanish.
    c0 = out_cnt[0];
    send(rand_word(), w);
    send(rand_word(), w);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", ov[0], 0);
    check("rst_mid_out_s", os[0], 0);
    check("rst_mid_in_ready", ir[0], 1);
    @(posedge clk); #1;
    idle(5);
    check("rst_no_stale", out_cnt[0] - c0, 0);

    // Random stream under random backpressure.
    c0 = out_cnt[0];
    for (int i = 0; i < N_RAND; i++) begin
      in_valid = 1'b1;
      in_m     = rand_word();
      a        = 1'b0;
      for (int n = 0; n < 200 && !a; n++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        a = ir[0];
        @(posedge clk); #1;
      end
      if (!a) check("rand_send_timeout", a, 1);
    end
    out_ready = 1'b1;
    idle(5);
    check("rand_outputs", out_cnt[0] - c0, N_RAND);
    for (int i = 0; i < ND; i++) check($sformatf("queue_drained[%0d]", i), exp_q[i].size(), 0);

`ifdef BLF_DUP_CHECK_EN
    begin
      logic [SWD-1:0] fv;
      in_valid = 1'b1;
      in_m     = rand_word();
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b0;
      @(negedge clk);
      check("dup_pre_force_valid", ov[0], 1);
      check("dup_pre_force_err", er[0], 0);
      fv = u_dut.s_q ^ 32'h0000_0001;
      force u_dut.s_q = fv;
      @(posedge clk); #1;
      @(negedge clk);
      check("dup_err_set", er[0], 1);
      release u_dut.s_q;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("dup_err_sticky", er[0], 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("dup_err_cleared", er[0], 0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      chk_en    = 1'b1;
    end
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
